// File: rtl/bumpy_pkg.sv
// Shared types and defaults for the Bumpy game-flow logic.
// Holds the game phase encoding, default game dimensions and tile codes.
// Tile codes are shared with the tile-map and collision blocks.
package bumpy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_DEAD = 3'd3,
    ST_WIN  = 3'd4,
    ST_OVER = 3'd5,
    ST_DONE = 3'd6
  } game_state_t;

  localparam int NUM_LEVELS_DEFAULT   = 4;
  localparam int NUM_LIVES_DEFAULT    = 3;
  // Two seconds of pause at 30 frames per second.
  localparam int DELAY_FRAMES_DEFAULT = 60;

  localparam logic [1:0] TILETYPE_EMPTY = 2'd0;
  localparam logic [1:0] TILETYPE_WALL  = 2'd1;
  localparam logic [1:0] TILETYPE_GIFT  = 2'd2;
  localparam logic [1:0] TILETYPE_HOLE  = 2'd3;

endpackage

// File: rtl/frame_event_latch.sv
// Turns a per-pixel hit level into a once-per-frame event flag.
// Latency: flag visible the cycle after the first hit of the frame.
// No backpressure; forced to 0 while disabled.
module frame_event_latch (
  input  logic clk,
  input  logic resetN,
  input  logic en,
  input  logic sof,
  input  logic hit,
  output logic q
);

  // Accumulate hits within a frame; the frame boundary restarts
  // capture, keeping a hit that lands on the boundary cycle itself.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)   q <= 1'b0;
    else if (!en)  q <= 1'b0;
    else if (sof)  q <= hit;
    else           q <= q | hit;
  end

endmodule

// File: rtl/bumpy_level_sequencer.sv
// Frame-rate game-flow sequencer: lives, levels, gifts and phase control.
// Latency: frame events act one cycle after startOfFrame; level_load one cycle after LOAD.
// No backpressure; start_key honoured only in IDLE, OVER and DONE.
module bumpy_level_sequencer
  import bumpy_pkg::*;
#(
  parameter int NUM_LEVELS   = NUM_LEVELS_DEFAULT,
  parameter int NUM_LIVES    = NUM_LIVES_DEFAULT,
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT,
  parameter int GIFT_W       = 4,
  localparam int LVL_W       = $clog2(NUM_LEVELS),
  localparam int LIV_W       = $clog2(NUM_LIVES + 1)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              start_key,
  input  logic              gift_hit,
  input  logic              hole_hit,
  input  logic              loss_hit,
  input  logic [GIFT_W-1:0] level_gifts,
  output logic [2:0]        game_state,
  output logic [LVL_W-1:0]  level,
  output logic [LIV_W-1:0]  lives,
  output logic [GIFT_W-1:0] gifts_left,
  output logic              gift_clear,
  output logic              level_load,
  output logic              freeze
);

  localparam int CNT_W = $clog2(DELAY_FRAMES + 1);

  game_state_t       state, state_nxt;
  logic [LVL_W-1:0]  level_nxt;
  logic [LIV_W-1:0]  lives_nxt;
  logic [GIFT_W-1:0] gifts_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              gift_l, hole_l, loss_l;
  logic              latch_en;

  // Latches only collect while play continues; a frame that leaves PLAY
  // drops whatever arrived on its boundary cycle.
  assign latch_en = (state == ST_PLAY) && (state_nxt == ST_PLAY);

  frame_event_latch u_gift_latch (
    .clk(clk), .resetN(resetN), .en(latch_en), .sof(startOfFrame), .hit(gift_hit), .q(gift_l)
  );
  frame_event_latch u_hole_latch (
    .clk(clk), .resetN(resetN), .en(latch_en), .sof(startOfFrame), .hit(hole_hit), .q(hole_l)
  );
  frame_event_latch u_loss_latch (
    .clk(clk), .resetN(resetN), .en(latch_en), .sof(startOfFrame), .hit(loss_hit), .q(loss_l)
  );

  assign game_state = state;
  assign freeze     = (state != ST_PLAY);
  assign gift_clear = (state == ST_PLAY) && (gifts_left == '0);

  // Phase register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next phase and counter updates; one frame action with loss > hole > gift.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    lives_nxt = lives;
    gifts_nxt = gifts_left;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_key) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        gifts_nxt = level_gifts;
        cnt_nxt   = '0;
        state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (startOfFrame) begin
          if (loss_l) begin
            if (lives != '0) lives_nxt = lives - LIV_W'(1);
            state_nxt = (lives <= LIV_W'(1)) ? ST_OVER : ST_DEAD;
          end else if (hole_l && gift_clear) begin
            state_nxt = ST_WIN;
          end else if (gift_l && gifts_left != '0) begin
            gifts_nxt = gifts_left - GIFT_W'(1);
          end
        end
      end
      ST_DEAD, ST_WIN: begin
        if (startOfFrame) begin
          if (cnt == CNT_W'(DELAY_FRAMES - 1)) begin
            cnt_nxt = '0;
            if (state == ST_DEAD) begin
              state_nxt = ST_LOAD;
            end else if (level == LVL_W'(NUM_LEVELS - 1)) begin
              state_nxt = ST_DONE;
            end else begin
              level_nxt = level + LVL_W'(1);
              state_nxt = ST_LOAD;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_OVER, ST_DONE: begin
        if (start_key) begin
          lives_nxt = LIV_W'(NUM_LIVES);
          level_nxt = '0;
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Game counters, pause counter and the reload strobe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level      <= '0;
      lives      <= LIV_W'(NUM_LIVES);
      gifts_left <= '0;
      cnt        <= '0;
      level_load <= 1'b0;
    end else begin
      level      <= level_nxt;
      lives      <= lives_nxt;
      gifts_left <= gifts_nxt;
      cnt        <= cnt_nxt;
      level_load <= (state == ST_LOAD);
    end
  end

endmodule

// File: tb/tb_bumpy_level_sequencer.sv
// Self-checking bench for bumpy_level_sequencer against a frame-level game model.
// Drives frames of random hits; checks phase, counters and strobes after each frame.
// All waits are bounded by the model's own frame counts.
module tb_bumpy_level_sequencer;

  localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_DEAD = 3;
  localparam int S_WIN = 4, S_OVER = 5, S_DONE = 6;
  localparam int DELAY = 60, LIVES = 3, LEVELS = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0, start_key = 1'b0;
  logic       gift_hit = 1'b0, hole_hit = 1'b0, loss_hit = 1'b0;
  logic [3:0] level_gifts;
  logic [2:0] game_state;
  logic [1:0] level;
  logic [1:0] lives;
  logic [3:0] gifts_left;
  logic       gift_clear, level_load, freeze;

  int n_tests = 0, n_fail = 0;
  int m_state = S_IDLE, m_level = 0, m_lives = LIVES, m_gifts = 0, m_wait = 0;
  int lvl_gifts [4] = '{3, 1, 0, 2};
  bit carry_g = 1'b0;

  always #5 clk = ~clk;

  // The level ROM, indexed by the level the game should be on.
  assign level_gifts = 4'(lvl_gifts[m_level]);

  bumpy_level_sequencer dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_key(start_key),
    .gift_hit(gift_hit), .hole_hit(hole_hit), .loss_hit(loss_hit), .level_gifts(level_gifts),
    .game_state(game_state), .level(level), .lives(lives), .gifts_left(gifts_left),
    .gift_clear(gift_clear), .level_load(level_load), .freeze(freeze)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Game rules applied once per frame boundary.
  task automatic model_sof(input bit g, input bit h, input bit l);
    case (m_state)
      S_PLAY: begin
        if (l) begin
          m_lives = m_lives - 1;
          m_state = (m_lives == 0) ? S_OVER : S_DEAD;
          m_wait  = DELAY;
        end else if (h && m_gifts == 0) begin
          m_state = S_WIN;
          m_wait  = DELAY;
        end else if (g && m_gifts > 0) begin
          m_gifts = m_gifts - 1;
        end
      end
      S_DEAD, S_WIN: begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          if (m_state == S_DEAD) m_state = S_LOAD;
          else if (m_level == LEVELS - 1) m_state = S_DONE;
          else begin
            m_level = m_level + 1;
            m_state = S_LOAD;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic reset_model();
    m_state = S_IDLE; m_level = 0; m_lives = LIVES; m_gifts = 0; carry_g = 1'b0;
  endtask

  // One LOAD cycle: expect PLAY with the reload strobe, then the strobe gone.
  task automatic do_load();
    tick();
    m_state = S_PLAY;
    m_gifts = lvl_gifts[m_level];
    n_tests++;
    if (game_state !== 3'(S_PLAY) || level_load !== 1'b1 || freeze !== 1'b0 ||
        gifts_left !== 4'(m_gifts) || gift_clear !== (m_gifts == 0)) begin
      n_fail++;
      $display("FAIL load_entry: st=%0d ld=%0b frz=%0b gifts=%0d gc=%0b, want st=2 ld=1 frz=0 gifts=%0d gc=%0b",
               game_state, level_load, freeze, gifts_left, gift_clear, m_gifts, m_gifts == 0);
    end
    tick();
    n_tests++;
    if (level_load !== 1'b0 || game_state !== 3'(S_PLAY)) begin
      n_fail++;
      $display("FAIL load_pulse_width: ld=%0b st=%0d, want ld=0 st=2", level_load, game_state);
    end
  endtask

  // One frame of len cycles with per-cycle hit percentages, then the frame pulse.
  task automatic run_frame(input int len, input int gp, input int hp, input int lp, input bit sof_gift);
    bit g, h, l;
    int prev;
    g = carry_g; h = 1'b0; l = 1'b0; carry_g = 1'b0;
    for (int i = 0; i < len - 1; i++) begin
      gift_hit = ($urandom_range(99) < gp);
      hole_hit = ($urandom_range(99) < hp);
      loss_hit = ($urandom_range(99) < lp);
      if (m_state == S_PLAY) begin
        g |= gift_hit; h |= hole_hit; l |= loss_hit;
      end
      tick();
    end
    startOfFrame = 1'b1; gift_hit = sof_gift; hole_hit = 1'b0; loss_hit = 1'b0;
    tick();
    startOfFrame = 1'b0; gift_hit = 1'b0;
    prev = m_state;
    model_sof(g, h, l);
    if (sof_gift && prev == S_PLAY && m_state == S_PLAY) carry_g = 1'b1;
    n_tests++;
    if (game_state !== 3'(m_state) || level !== 2'(m_level) || lives !== 2'(m_lives) ||
        gifts_left !== 4'(m_gifts)) begin
      n_fail++;
      $display("FAIL frame_counters: st=%0d lvl=%0d lives=%0d gifts=%0d, want st=%0d lvl=%0d lives=%0d gifts=%0d",
               game_state, level, lives, gifts_left, m_state, m_level, m_lives, m_gifts);
    end
    n_tests++;
    if (freeze !== (m_state != S_PLAY) || gift_clear !== (m_state == S_PLAY && m_gifts == 0) ||
        level_load !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_flags: frz=%0b gc=%0b ld=%0b, want frz=%0b gc=%0b ld=0",
               freeze, gift_clear, level_load, m_state != S_PLAY, m_state == S_PLAY && m_gifts == 0);
    end
    if (m_state == S_LOAD) do_load();
  endtask

  task automatic press_start();
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    if (m_state == S_OVER || m_state == S_DONE) begin
      m_lives = LIVES; m_level = 0; m_state = S_LOAD;
    end else if (m_state == S_IDLE) begin
      m_state = S_LOAD;
    end
    n_tests++;
    if (game_state !== 3'(m_state) || level !== 2'(m_level) || lives !== 2'(m_lives)) begin
      n_fail++;
      $display("FAIL start_key: st=%0d lvl=%0d lives=%0d, want st=%0d lvl=%0d lives=%0d",
               game_state, level, lives, m_state, m_level, m_lives);
    end
    if (m_state == S_LOAD) do_load();
  endtask

  task automatic wait_pause();
    while (m_state == S_DEAD || m_state == S_WIN) run_frame(3, 30, 30, 30, 1'b0);
  endtask

  task automatic win_level();
    while (m_gifts > 0) run_frame(3, 100, 0, 0, 1'b0);
    run_frame(3, 0, 100, 0, 1'b0);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    n_tests++;
    if (game_state !== 3'(S_IDLE) || level !== 2'd0 || lives !== 2'd3 || gifts_left !== 4'd0 ||
        freeze !== 1'b1 || gift_clear !== 1'b0 || level_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: st=%0d lvl=%0d lives=%0d gifts=%0d frz=%0b gc=%0b ld=%0b, want 0 0 3 0 1 0 0",
               game_state, level, lives, gifts_left, freeze, gift_clear, level_load);
    end
    #5 resetN = 1'b1;
    reset_model();
    tick();
    run_frame(4, 50, 50, 50, 1'b0);
  endtask

  task automatic test_start();
    press_start();
  endtask

  task automatic test_gift_once_per_frame();
    run_frame(41, 100, 0, 0, 1'b0);
    run_frame(10, 0, 100, 0, 1'b0);
    run_frame(41, 100, 0, 0, 1'b0);
    press_start();
    run_frame(41, 100, 0, 0, 1'b0);
    run_frame(20, 100, 0, 0, 1'b0);
  endtask

  task automatic test_win_next_level();
    run_frame(5, 0, 100, 0, 1'b0);
    wait_pause();
  endtask

  task automatic test_loss_to_over();
    for (int k = 0; k < 3; k++) begin
      run_frame(4, 0, 0, 100, 1'b0);
      wait_pause();
    end
    press_start();
  endtask

  task automatic test_loss_priority();
    while (m_gifts > 0) run_frame(3, 100, 0, 0, 1'b0);
    run_frame(6, 0, 100, 100, 1'b0);
    wait_pause();
  endtask

  task automatic test_same_cycle_hit();
    run_frame(4, 0, 0, 0, 1'b1);
    run_frame(4, 0, 0, 0, 1'b0);
  endtask

  task automatic test_last_level();
    while (m_state != S_DONE) begin
      win_level();
      wait_pause();
    end
    press_start();
  endtask

  task automatic test_reset_mid_win();
    for (int k = 0; k < LEVELS; k++) begin
      win_level();
      if (k < LEVELS - 1) wait_pause();
    end
    run_frame(3, 0, 0, 0, 1'b0);
    resetN = 1'b0;
    #1;
    n_tests++;
    if (game_state !== 3'(S_IDLE) || level !== 2'd0 || lives !== 2'd3 || gifts_left !== 4'd0 ||
        freeze !== 1'b1 || level_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_win: st=%0d lvl=%0d lives=%0d gifts=%0d frz=%0b ld=%0b, want 0 0 3 0 1 0",
               game_state, level, lives, gifts_left, freeze, level_load);
    end
    #3 resetN = 1'b1;
    reset_model();
    tick();
  endtask

  task automatic test_random();
    press_start();
    for (int f = 0; f < 300; f++) begin
      if (m_state == S_OVER || m_state == S_DONE || $urandom_range(19) == 0) press_start();
      run_frame($urandom_range(6, 2), 12, 6, 3, ($urandom_range(3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_gift_once_per_frame();
    test_win_next_level();
    test_loss_to_over();
    test_loss_priority();
    test_same_cycle_hit();
    test_last_level();
    test_reset_mid_win();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bumpy_level_sequencer.md
Name: bumpy_level_sequencer

Overview:
- Frame-rate game-flow controller for the Bumpy game, sitting above the per-pixel collision logic.
- Consumes the per-pixel gift / hole / loss hit levels and converts them into once-per-frame events.
- Tracks gifts remaining, lives and current level.
- Sequences start, play, death, level-win, game-over and game-complete phases, driving level reload and motion freeze for the object/tile blocks.

Parameters:
- NUM_LEVELS, 4, number of levels; level index width LVL_W = $clog2(NUM_LEVELS).
- NUM_LIVES, 3, lives at game start; lives width LIV_W = $clog2(NUM_LIVES+1).
- DELAY_FRAMES, 60, frames held in the DEAD and WIN pause states (2 s at 30 Hz).
- GIFT_W, 4, width of the gift counter.

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_key  in  1  one-cycle start/restart pulse, already debounced
- gift_hit  in  1  per-pixel level: ball overlaps a gift tile
- hole_hit  in  1  per-pixel level: ball overlaps a hole tile
- loss_hit  in  1  per-pixel level: ball overlaps the bottom border
- level_gifts  in  GIFT_W  gift count of the level being loaded, from the level ROM
- game_state  out  3  IDLE=0, LOAD=1, PLAY=2, DEAD=3, WIN=4, OVER=5, DONE=6
- level  out  LVL_W  current level index
- lives  out  LIV_W  lives remaining
- gifts_left  out  GIFT_W  gifts still to collect
- gift_clear  out  1  gifts_left==0 while in PLAY; enables drawing of the hole
- level_load  out  1  one-cycle pulse; reloads the tile map and ball start position
- freeze  out  1  high in every state except PLAY; holds ball motion

Behaviour:
- Reset is resetN, asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, level=0, lives=NUM_LIVES, gifts_left=0, all event latches=0, delay counter=0, level_load=0. freeze=1 and gift_clear=0 follow from IDLE.
- Reset asserted mid-operation returns to these values immediately, from any state.
- Event latches (gift_l, hole_l, loss_l):
  - In PLAY, each latch sets on any cycle its hit input is high.
  - All latches clear on startOfFrame after being evaluated.
  - In any state other than PLAY, the latches are held at 0.
- Frame evaluation happens only in PLAY on startOfFrame, using the latched values. Priority is loss > hole > gift; one action per frame.
  - loss_l: lives decrements. Go to OVER if the new value is 0, else DEAD.
  - hole_l and gift_clear: go to WIN. A hole hit while gifts remain is ignored.
  - gift_l and gifts_left>0: gifts_left decrements by exactly 1, regardless of how many pixels or gifts overlapped. It saturates at 0.
- IDLE: start_key -> LOAD.
- LOAD, one cycle: level_load=1, gifts_left<=level_gifts, delay counter cleared -> PLAY.
  - If level_gifts==0, gift_clear rises on the first PLAY cycle.
- DEAD: counts startOfFrame pulses. At count DELAY_FRAMES-1 -> LOAD with the same level (gifts reload).
- WIN: same delay. Then:
  - level==NUM_LEVELS-1 -> DONE;
  - otherwise level increments -> LOAD.
- OVER and DONE: start_key -> lives=NUM_LIVES, level=0 -> LOAD.
- start_key is ignored in LOAD, PLAY, DEAD and WIN.
- Latency:
  - a hit in frame N updates counters and state one cycle after the startOfFrame that begins frame N+1;
  - level_load asserts exactly one cycle after LOAD is entered.
- Simultaneous startOfFrame and a hit in the same cycle: the hit is counted in the next frame. The latch is cleared and then re-set by that same-cycle hit.
- Level, gift and lives arithmetic is unsigned and never wraps. Guards are as stated above; level never exceeds NUM_LEVELS-1.

Decomposition:
- Package bumpy_pkg holds:
  - game_state_t enum with the encodings above;
  - NUM_LEVELS, NUM_LIVES and DELAY_FRAMES defaults;
  - the TILETYPE_* 2-bit codes shared with the tile and collision logic.
- One sub-module, frame_event_latch: a set-on-level, clear-on-startOfFrame, enable-gated latch. It is instantiated three times (gift, hole, loss).

Test Plan:
- Reset, start_key, level_gifts=3: state goes IDLE->LOAD->PLAY; level_load is high for 1 cycle; gifts_left=3; freeze drops to 0.
- gift_hit high for 40 cycles within one frame: after the next startOfFrame, gifts_left=2, not lower. Repeat for two more frames -> gifts_left=0 and gift_clear=1.
- hole_hit while gifts_left=2: no state change. hole_hit after clear on level 0: WIN; after 60 startOfFrame pulses, level=1 and LOAD pulses.
- loss_hit three times across lives 3->2->1: DEAD, then reload of the same level with gifts restored. The third hit gives lives=0 and OVER; start_key then gives lives=3, level=0, LOAD.
- loss_hit and hole_hit in the same frame with gift_clear=1: loss wins, lives decrements, state=DEAD.
- Clear the last level (level=3): WIN then DONE. resetN pulsed mid-WIN: state=IDLE, level=0, lives=3 immediately.
